// File: rtl/cv32e40x_rf_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters plus a global
// total, producing RAW, WAW and capacity stalls for the ID stage.
module cv32e40x_rf_scoreboard #(
  parameter int REGFILE_NUM_READ_PORTS = 2,
  parameter int MAX_PER_REG            = 3,
  parameter int MAX_TOTAL              = 4,
  parameter int WB_BYPASS              = 1,
  localparam int CNT_W = $clog2(MAX_PER_REG + 1),
  localparam int TOT_W = $clog2(MAX_TOTAL + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                issue_fire_i,
  input  logic                                issue_we_i,
  input  logic [4:0]                          issue_waddr_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0]   rf_re_i,
  input  logic [5*REGFILE_NUM_READ_PORTS-1:0] rf_raddr_i,
  input  logic                                id_we_i,
  input  logic [4:0]                          id_waddr_i,
  input  logic                                retire_valid_i,
  input  logic [4:0]                          retire_waddr_i,
  input  logic                                flush_i,
  output logic [REGFILE_NUM_READ_PORTS-1:0]   raw_stall_port_o,
  output logic                                stall_o,
  output logic [TOT_W-1:0]                    outstanding_o,
  output logic                                busy_o,
  output logic                                underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_REG);
  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_TOTAL);

  logic [CNT_W-1:0]                  r_cnt [32];
  logic [TOT_W-1:0]                  r_total;
  logic                              r_underflow;

  logic                              w_issueEv;
  logic                              w_retireEv;
  logic                              w_sameReg;
  logic                              w_issueAcc;
  logic                              w_retireAcc;
  logic                              w_underflow;
  logic                              w_wawStall;
  logic                              w_capStall;
  logic [REGFILE_NUM_READ_PORTS-1:0] w_raw;

  assign w_issueEv  = issue_fire_i & issue_we_i & (issue_waddr_i != 5'd0);
  assign w_retireEv = retire_valid_i & (retire_waddr_i != 5'd0);
  assign w_sameReg  = w_issueEv & w_retireEv & (issue_waddr_i == retire_waddr_i);

  // An issue into a saturated counter (or full total) is dropped so the counters never wrap.
  assign w_issueAcc  = w_issueEv & ~w_sameReg & (r_cnt[issue_waddr_i] != CNT_MAX) &
                       (r_total != TOT_MAX);
  assign w_retireAcc = w_retireEv & ~w_sameReg & (r_cnt[retire_waddr_i] != '0);
  assign w_underflow = w_retireEv & ~w_sameReg & (r_cnt[retire_waddr_i] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= '0;
      end
      r_total     <= '0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= '0;
      end
      r_total <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_issueAcc && (issue_waddr_i == 5'(i))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_retireAcc && (retire_waddr_i == 5'(i))) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      r_total <= r_total + TOT_W'(w_issueAcc) - TOT_W'(w_retireAcc);
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // A retire of the last pending write forwards from WB, so the reader need not wait.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < REGFILE_NUM_READ_PORTS; k++) begin
      if (rf_re_i[k] && (rf_raddr_i[5*k +: 5] != 5'd0) && (r_cnt[rf_raddr_i[5*k +: 5]] != '0)) begin
        w_raw[k] = 1'b1;
        if ((WB_BYPASS != 0) && w_retireEv && (retire_waddr_i == rf_raddr_i[5*k +: 5]) &&
            (r_cnt[rf_raddr_i[5*k +: 5]] == CNT_W'(1))) begin
          w_raw[k] = 1'b0;
        end
      end
    end
  end

  assign w_wawStall = id_we_i & (id_waddr_i != 5'd0) & (r_cnt[id_waddr_i] == CNT_MAX);
  assign w_capStall = id_we_i & (id_waddr_i != 5'd0) & (r_total == TOT_MAX);

  assign raw_stall_port_o = w_raw;
  assign stall_o          = (|w_raw) | w_wawStall | w_capStall;
  assign outstanding_o    = r_total;
  assign busy_o           = (r_total != '0);
  assign underflow_err_o  = r_underflow;

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
// Bench for cv32e40x_rf_scoreboard: directed vector table, then random traffic
// compared against a pending-write-count model.
module tb_cv32e40x_rf_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_fire_i;
  logic       issue_we_i;
  logic [4:0] issue_waddr_i;
  logic [1:0] rf_re_i;
  logic [9:0] rf_raddr_i;
  logic       id_we_i;
  logic [4:0] id_waddr_i;
  logic       retire_valid_i;
  logic [4:0] retire_waddr_i;
  logic       flush_i;
  logic [1:0] raw_stall_port_o;
  logic       stall_o;
  logic [2:0] outstanding_o;
  logic       busy_o;
  logic       underflow_err_o;

  int nVec = 0;
  int nMis = 0;

  cv32e40x_rf_scoreboard #(
    .REGFILE_NUM_READ_PORTS(2),
    .MAX_PER_REG(3),
    .MAX_TOTAL(4),
    .WB_BYPASS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue_fire_i(issue_fire_i),
    .issue_we_i(issue_we_i),
    .issue_waddr_i(issue_waddr_i),
    .rf_re_i(rf_re_i),
    .rf_raddr_i(rf_raddr_i),
    .id_we_i(id_we_i),
    .id_waddr_i(id_waddr_i),
    .retire_valid_i(retire_valid_i),
    .retire_waddr_i(retire_waddr_i),
    .flush_i(flush_i),
    .raw_stall_port_o(raw_stall_port_o),
    .stall_o(stall_o),
    .outstanding_o(outstanding_o),
    .busy_o(busy_o),
    .underflow_err_o(underflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rstn, ifire, iwe, iaddr, re, ra0, ra1, idwe, idaddr, rv, raddr, flush;
    int eraw, estall, eout, euf;
  } vec_t;

  vec_t tbl[$];

  // Model state: number of pending writes per register and the sticky error flag.
  int  mCnt [32];
  bit  mUf;

  function automatic void mk(input int rstn, ifire, iwe, iaddr, re, ra0, ra1, idwe, idaddr,
                             rv, raddr, flush, eraw, estall, eout, euf);
    vec_t v;
    v = '{rstn, ifire, iwe, iaddr, re, ra0, ra1, idwe, idaddr, rv, raddr, flush,
          eraw, estall, eout, euf};
    tbl.push_back(v);
  endfunction

  function automatic int mTotal();
    int s = 0;
    foreach (mCnt[i]) s += mCnt[i];
    return s;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n          = v.rstn[0];
    issue_fire_i   = v.ifire[0];
    issue_we_i     = v.iwe[0];
    issue_waddr_i  = v.iaddr[4:0];
    rf_re_i        = v.re[1:0];
    rf_raddr_i     = {v.ra1[4:0], v.ra0[4:0]};
    id_we_i        = v.idwe[0];
    id_waddr_i     = v.idaddr[4:0];
    retire_valid_i = v.rv[0];
    retire_waddr_i = v.raddr[4:0];
    flush_i        = v.flush[0];
  endtask

  task automatic checkAll(input string tag, input int eraw, estall, eout, euf);
    checkOutput({tag, " raw"}, int'(raw_stall_port_o), eraw);
    checkOutput({tag, " stall"}, int'(stall_o), estall);
    checkOutput({tag, " outstanding"}, int'(outstanding_o), eout);
    checkOutput({tag, " busy"}, int'(busy_o), int'(eout != 0));
    checkOutput({tag, " underflow"}, int'(underflow_err_o), euf);
  endtask

  // Expected outputs follow from the pending counts; the model state advances after each edge.
  task automatic modelStep(input vec_t v, output int eraw, output int estall);
    bit issueEv, retireEv, waw, cap;
    int ra[2];
    issueEv  = (v.ifire != 0) && (v.iwe != 0) && (v.iaddr != 0);
    retireEv = (v.rv != 0) && (v.raddr != 0);
    ra[0] = v.ra0;
    ra[1] = v.ra1;
    eraw = 0;
    for (int k = 0; k < 2; k++) begin
      if (v.re[k] && ra[k] != 0 && mCnt[ra[k]] > 0 &&
          !(retireEv && v.raddr == ra[k] && mCnt[ra[k]] == 1))
        eraw |= (1 << k);
    end
    waw = (v.idwe != 0) && (v.idaddr != 0) && (mCnt[v.idaddr] >= 3);
    cap = (v.idwe != 0) && (v.idaddr != 0) && (mTotal() >= 4);
    estall = int'((eraw != 0) || waw || cap);
  endtask

  task automatic modelUpdate(input vec_t v);
    bit issueEv, retireEv;
    issueEv  = (v.ifire != 0) && (v.iwe != 0) && (v.iaddr != 0);
    retireEv = (v.rv != 0) && (v.raddr != 0);
    if (v.rstn == 0) begin
      foreach (mCnt[i]) mCnt[i] = 0;
      mUf = 1'b0;
    end else if (v.flush != 0) begin
      foreach (mCnt[i]) mCnt[i] = 0;
    end else if (!(issueEv && retireEv && v.iaddr == v.raddr)) begin
      if (issueEv && mCnt[v.iaddr] < 3) mCnt[v.iaddr]++;
      if (retireEv) begin
        if (mCnt[v.raddr] == 0) mUf = 1'b1;
        else mCnt[v.raddr]--;
      end
    end
  endtask

  initial begin
    vec_t v;
    int eraw, estall;

    // Columns: rstn ifire iwe iaddr | re ra0 ra1 | idwe idaddr | rv raddr | flush | raw stall out uf
    mk(1,0,0,0,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,1,1,0,  0,0,0,  0,0,  1,0,  0,  0,0,0,0);
    mk(1,1,1,5,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,0,0,0,  1,5,0,  0,0,  0,0,  0,  1,1,1,0);
    mk(1,0,0,0,  1,5,0,  0,0,  1,5,  0,  0,0,1,0);
    mk(1,0,0,0,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,1,1,7,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,1,1,7,  0,0,0,  0,0,  0,0,  0,  0,0,1,0);
    mk(1,1,1,7,  0,0,0,  0,0,  0,0,  0,  0,0,2,0);
    mk(1,0,0,0,  0,0,0,  1,7,  1,7,  0,  0,1,3,0);
    mk(1,0,0,0,  0,0,0,  1,7,  0,0,  0,  0,0,2,0);
    mk(1,0,0,0,  2,0,7,  0,0,  1,7,  0,  2,1,2,0);
    mk(1,0,0,0,  2,0,7,  0,0,  1,7,  0,  0,0,1,0);
    mk(1,0,0,0,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,1,1,1,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,1,1,2,  0,0,0,  0,0,  0,0,  0,  0,0,1,0);
    mk(1,1,1,3,  0,0,0,  0,0,  0,0,  0,  0,0,2,0);
    mk(1,1,1,4,  0,0,0,  0,0,  0,0,  0,  0,0,3,0);
    mk(1,0,0,0,  0,0,0,  1,9,  0,0,  0,  0,1,4,0);
    mk(1,0,0,0,  0,0,0,  1,9,  1,1,  0,  0,1,4,0);
    mk(1,0,0,0,  0,0,0,  0,9,  0,0,  0,  0,0,3,0);
    mk(1,1,1,3,  0,0,0,  0,0,  1,3,  0,  0,0,3,0);
    mk(1,0,0,0,  2,0,3,  0,0,  0,0,  0,  2,1,3,0);
    mk(1,1,1,4,  0,0,0,  0,0,  0,0,  0,  0,0,3,0);
    mk(1,0,0,0,  1,4,0,  0,0,  0,0,  0,  1,1,4,0);
    mk(1,1,1,6,  0,0,0,  0,0,  1,4,  1,  0,0,4,0);
    mk(1,0,0,0,  3,4,6,  0,0,  0,0,  0,  0,0,0,0);
    mk(1,0,0,0,  0,0,0,  0,0,  1,10, 0,  0,0,0,0);
    mk(1,1,1,11, 0,0,0,  0,0,  0,0,  0,  0,0,0,1);
    mk(1,0,0,0,  0,0,0,  0,0,  1,11, 0,  0,0,1,1);
    mk(1,0,0,0,  3,0,0,  1,0,  0,0,  0,  0,0,0,1);
    mk(0,0,0,0,  0,0,0,  0,0,  0,0,  0,  0,0,0,1);
    mk(1,0,0,0,  0,0,0,  0,0,  0,0,  0,  0,0,0,0);

    v = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    applyStimulus(v);
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      checkAll($sformatf("vec%0d", i), tbl[i].eraw, tbl[i].estall, tbl[i].eout, tbl[i].euf);
      @(posedge clk);
      @(negedge clk);
    end

    foreach (mCnt[i]) mCnt[i] = 0;
    mUf = 1'b0;

    for (int n = 0; n < 600; n++) begin
      v.rstn   = int'($urandom_range(0, 99) != 0);
      v.flush  = int'($urandom_range(0, 39) == 0);
      v.iwe    = int'($urandom_range(0, 3) != 0);
      v.iaddr  = int'($urandom_range(0, 12));
      v.ifire  = int'($urandom_range(0, 1));
      v.idwe   = int'($urandom_range(0, 1));
      v.idaddr = ($urandom_range(0, 1) != 0) ? v.iaddr : int'($urandom_range(0, 12));
      v.re     = int'($urandom_range(0, 3));
      v.ra0    = int'($urandom_range(0, 12));
      v.ra1    = int'($urandom_range(0, 12));
      v.rv     = int'($urandom_range(0, 1));
      v.raddr  = int'($urandom_range(0, 12));
      // Keep the issue side well-behaved: a real ID stage never fires into a full scoreboard.
      if (v.iwe != 0 && v.iaddr != 0 && (mCnt[v.iaddr] >= 3 || mTotal() >= 4)) v.ifire = 0;
      applyStimulus(v);
      modelStep(v, eraw, estall);
      #1;
      checkAll($sformatf("rnd%0d", n), eraw, estall, mTotal(), int'(mUf));
      @(posedge clk);
      modelUpdate(v);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/cv32e40x_rf_scoreboard.md
Name: cv32e40x_rf_scoreboard

Overview:
- Parametrised register-file hazard scoreboard; successor to the fixed two-port bypass/stall logic inside the controller.
- Tracks in-flight register writes with a per-register pending counter, so multiple outstanding writers per register are supported.
- Sits beside the controller FSM: ID queries it each cycle; WB retires writes; the controller flushes it on kill.
- Generates RAW, WAW and capacity stalls for ID, for any number of read ports.

Parameters:
REGFILE_NUM_READ_PORTS, 2, number of ID register read ports checked (1..3)
MAX_PER_REG, 3, maximum outstanding writes per register (counter width CNT_W = $clog2(MAX_PER_REG+1))
MAX_TOTAL, 4, maximum outstanding writes across all registers (width TOT_W = $clog2(MAX_TOTAL+1))
WB_BYPASS, 1, when 1 a same-cycle retire of the last pending write to a register clears that register's RAW stall

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
issue_fire_i  input  1  ID instruction leaves ID this cycle (handshake completed)
issue_we_i  input  1  issuing instruction writes the register file
issue_waddr_i  input  5  destination register of the issuing instruction
rf_re_i  input  REGFILE_NUM_READ_PORTS  read enable per ID read port
rf_raddr_i  input  5*REGFILE_NUM_READ_PORTS  read address per port, port k at bits [5k+4:5k]
id_we_i  input  1  instruction currently in ID writes the register file
id_waddr_i  input  5  destination register of the instruction in ID
retire_valid_i  input  1  WB write to the register file commits this cycle
retire_waddr_i  input  5  register written by WB
flush_i  input  1  all in-flight (issued, not retired) writes are killed
raw_stall_port_o  output  REGFILE_NUM_READ_PORTS  per-port RAW hazard
stall_o  output  1  OR of RAW, WAW and capacity stalls
outstanding_o  output  TOT_W  current total pending writes
busy_o  output  1  outstanding_o != 0
underflow_err_o  output  1  sticky: retire seen for a register with zero pending count

Behaviour:
- Reset (rst_n low at a clk edge): all per-register counters = 0; total = 0; underflow_err_o = 0. Consequently stall_o = 0, raw_stall_port_o = 0, busy_o = 0.
- x0 is never tracked:
  - an issue or retire with address 0 has no effect;
  - a read of x0 never stalls.
- Issue event: issue_fire_i & issue_we_i & issue_waddr_i != 0.
- Retire event: retire_valid_i & retire_waddr_i != 0.
- Counter update at clk edge, priority order:
  - flush_i: all counters and total = 0. Same-cycle issue and retire are ignored.
  - else, issue and retire on the same register: that count is unchanged, total is unchanged.
  - else, each event independently: issue does cnt+1 and total+1; retire does cnt-1 and total-1.
  - retire on a count of 0: no decrement; underflow_err_o set to 1 and held until reset.
- The stall logic guarantees no overflow. If an issue arrives at saturation anyway (stall ignored), the counter holds at its maximum.
- Per-port RAW, combinational from the registered state: raw_stall_port_o[k] = rf_re_i[k] & raddr != 0 & cnt[raddr] != 0, EXCEPT when all of the following hold, in which case it is 0:
  - WB_BYPASS = 1;
  - retire event on raddr this cycle;
  - cnt[raddr] == 1.
- WAW/capacity stalls apply only when id_we_i & id_waddr_i != 0:
  - WAW stall: cnt[id_waddr_i] == MAX_PER_REG.
  - Capacity stall: total == MAX_TOTAL.
  - A same-cycle retire does not relieve a WAW or capacity stall (these are registered-state only; avoids a retire-to-issue timing path).
- stall_o = |raw_stall_port_o | WAW stall | capacity stall. It is purely combinational; the bench must not assume the block gates issue_fire_i itself.
- outstanding_o and busy_o are driven directly from registered state (no combinational input paths).
- Latency: an issue at edge N affects stall outputs from cycle N+1; a retire at edge N is visible combinationally in cycle N through the bypass, otherwise from N+1.
- Reset mid-operation overrides flush, issue and retire.

Test Plan:
1. Reset, then issue x5; next cycle read x5 on port 0 -> raw_stall_port_o = 2'b01, stall_o = 1, outstanding_o = 1. Retire x5 the same cycle as the read with WB_BYPASS = 1 -> raw_stall_port_o[0] = 0 in that cycle; outstanding_o = 0 after the edge.
2. Issue x7 three times, then ID presents id_we_i = 1, id_waddr_i = 7 -> WAW stall, stall_o = 1. Retire x7 once -> stall clears the following cycle; count = 2.
3. Issue x1, x2, x3, x4 -> outstanding_o = 4, busy_o = 1. ID writing x9 -> capacity stall. ID with id_we_i = 0 and no reads -> stall_o = 0.
4. Issue x3 and retire x3 in the same cycle, with count = 1 beforehand -> count stays 1, outstanding_o unchanged.
5. Count x4 = 2, then flush_i together with issue x6 and retire x4 -> all counts 0, outstanding_o = 0, busy_o = 0, no underflow.
6. Retire x10 with count 0 -> underflow_err_o = 1, held through subsequent traffic, cleared only by rst_n = 0. Read x0 with rf_re_i set -> never stalls.
